if_id_buffer: RTL and testbench

IF/ID pipeline buffer for the 16-bit processor: the receiving end of the fetch stage's `PC+4` / instruction outputs. Captures each fetched word, holds it for the decode stage under hazard stalls through a 2-entry skid buffer, discards wrong-path words on a taken-branch flush, and presents pre-split instruction fields to ID. Sits between the IF stage and the ID stage; its `inReady` is the PC-write enable back to IF.

---
 rtl/if_id_buffer_if.sv | 35 +++
 rtl/if_id_buffer.sv | 124 ++++++++++++
 tb/tb_if_id_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// IF -> IF/ID buffer -> ID bus: fetched word handshake in, decoded head entry out.
interface if_id_buffer_if;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FIELD_W = 4;

    logic [DATA_W-1:0]  inPC4;
    logic [DATA_W-1:0]  inInstruction;
    logic               inValid;
    logic               inReady;
    logic               flush;
    logic               stall;
    logic               outValid;
    logic [DATA_W-1:0]  outPC4;
    logic [DATA_W-1:0]  outInstruction;
    logic [FIELD_W-1:0] outOpcode;
    logic [FIELD_W-1:0] outRs;
    logic [FIELD_W-1:0] outRt;
    logic [FIELD_W-1:0] outRd;
    logic [DATA_W-1:0]  outImm;
    logic [DATA_W-1:0]  stallCount;

    // Environment side: fetch stage plus ID / hazard control.
    modport master (
        output inPC4, inInstruction, inValid, flush, stall,
        input  inReady, outValid, outPC4, outInstruction,
        input  outOpcode, outRs, outRt, outRd, outImm, stallCount
    );

    // Buffer side.
    modport slave (
        input  inPC4, inInstruction, inValid, flush, stall,
        output inReady, outValid, outPC4, outInstruction,
        output outOpcode, outRs, outRt, outRd, outImm, stallCount
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: main entry plus one skid entry, flushable, with
// pre-split instruction fields and a saturating stall-cycle counter.
module if_id_buffer (
    input  logic            clock,
    input  logic            reset,
    if_id_buffer_if.slave   bus
);
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_pc4;
    logic [DATA_W-1:0]   r_main_instr;
    logic [DATA_W-1:0]   r_skid_pc4;
    logic [DATA_W-1:0]   r_skid_instr;
    logic [DATA_W-1:0]   r_stall_count;
    logic                w_take;
    logic                w_acc;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_take = r_out_valid && !bus.stall;
    assign w_acc  = bus.inValid && r_in_ready;

    // Occupancy register; the valid/ready flags are registered decodes of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != ST_EMPTY);
            r_in_ready  <= (w_next_state != ST_FULL);
        end
    end

    // Next occupancy and entry-load strobes; flush discards everything, including the offered word.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_next_state   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_take) begin
                        w_next_state   = w_acc ? ST_ONE : ST_EMPTY;
                        w_load_main_in = w_acc;
                    end else if (w_acc) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_take) begin
                        w_next_state     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_pc4   <= '0;
            r_main_instr <= '0;
            r_skid_pc4   <= '0;
            r_skid_instr <= '0;
        end else begin
            if (w_load_main_skid) begin
                r_main_pc4   <= r_skid_pc4;
                r_main_instr <= r_skid_instr;
            end else if (w_load_main_in) begin
                r_main_pc4   <= bus.inPC4;
                r_main_instr <= bus.inInstruction;
            end
            if (w_load_skid) begin
                r_skid_pc4   <= bus.inPC4;
                r_skid_instr <= bus.inInstruction;
            end
        end
    end

    // Saturating count of cycles where a valid head is held by a stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (r_out_valid && bus.stall && (r_stall_count != {DATA_W{1'b1}})) begin
            r_stall_count <= r_stall_count + DATA_W'(1);
        end
    end

    assign bus.inReady        = r_in_ready;
    assign bus.outValid       = r_out_valid;
    assign bus.outPC4         = r_main_pc4;
    assign bus.outInstruction = r_main_instr;
    assign bus.outOpcode      = r_main_instr[15:12];
    assign bus.outRs          = r_main_instr[11:8];
    assign bus.outRt          = r_main_instr[7:4];
    assign bus.outRd          = r_main_instr[3:0];
    assign bus.outImm         = {{12{r_main_instr[3]}}, r_main_instr[3:0]};
    assign bus.stallCount     = r_stall_count;
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_if_id_buffer;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
    } word_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    word_t       mq[$];
    logic        m_ready;
    logic [15:0] m_cnt;

    if_id_buffer_if bus ();

    if_id_buffer u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge; the model advances from the inputs seen before the edge.
    task automatic step();
        bit take;
        bit acc;
        bit cnt_inc;
        word_t w;
        take    = (mq.size() > 0) && !bus.stall;
        acc     = bus.inValid && m_ready;
        cnt_inc = (mq.size() > 0) && bus.stall && (m_cnt != 16'hFFFF);
        w.pc    = bus.inPC4;
        w.ins   = bus.inInstruction;
        @(posedge clock);
        #1;
        if (reset) begin
            mq.delete();
            m_cnt = 16'h0000;
        end else begin
            if (cnt_inc) m_cnt = m_cnt + 16'd1;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc) mq.push_back(w);
            end
        end
        m_ready = (mq.size() < 2);
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic st, input logic fl);
        bus.inValid       = v;
        bus.inPC4         = pc;
        bus.inInstruction = ins;
        bus.stall         = st;
        bus.flush         = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.outValid); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.inReady); end
        n_checks++; if (bus.stallCount !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h want 0000", bus.stallCount); end
        n_checks++; if (bus.outPC4 !== 16'h0000) begin n_fail++; $display("FAIL reset_pc4: got %h want 0000", bus.outPC4); end
        n_checks++; if (bus.outInstruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", bus.outInstruction); end
        n_checks++; if (bus.outImm !== 16'h0000) begin n_fail++; $display("FAIL reset_imm: got %h want 0000", bus.outImm); end
    endtask

    task automatic test_stream();
        logic [15:0] pcs [3];
        logic [15:0] ins [3];
        pcs = '{16'h0002, 16'h0004, 16'h0006};
        ins = '{16'h1234, 16'hABCD, 16'hF00F};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], ins[i], 1'b0, 1'b0);
            step();
            n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b want 1", i, bus.outValid); end
            n_checks++; if (bus.outPC4 !== pcs[i]) begin n_fail++; $display("FAIL stream_pc%0d: got %h want %h", i, bus.outPC4, pcs[i]); end
            n_checks++; if (bus.outInstruction !== ins[i]) begin n_fail++; $display("FAIL stream_instr%0d: got %h want %h", i, bus.outInstruction, ins[i]); end
            if (i == 0) begin
                n_checks++; if (bus.outImm !== 16'h0004) begin n_fail++; $display("FAIL stream_imm_1234: got %h want 0004", bus.outImm); end
            end
            if (i == 1) begin
                n_checks++; if ({bus.outOpcode, bus.outRs, bus.outRt, bus.outRd} !== 16'hABCD) begin n_fail++; $display("FAIL stream_fields_abcd: got %h%h%h%h want ABCD", bus.outOpcode, bus.outRs, bus.outRt, bus.outRd); end
                n_checks++; if (bus.outImm !== 16'hFFFD) begin n_fail++; $display("FAIL stream_imm_abcd: got %h want FFFD", bus.outImm); end
            end
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", bus.outValid); end
    endtask

    task automatic test_stall_fill();
        do_reset();
        drive(1'b1, 16'h0102, 16'h1111, 1'b1, 1'b0);
        step();
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL fill_ready1: got %b want 1", bus.inReady); end
        drive(1'b1, 16'h0104, 16'h2222, 1'b1, 1'b0);
        step();
        n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL fill_ready2: got %b want 0", bus.inReady); end
        drive(1'b1, 16'h0106, 16'h3333, 1'b1, 1'b0);
        step();
        n_checks++; if (bus.inReady !== 1'b0 || bus.outPC4 !== 16'h0102) begin n_fail++; $display("FAIL fill_held: got ready %b pc %h want 0 0102", bus.inReady, bus.outPC4); end
        bus.stall = 1'b0;
        step();
        n_checks++; if (bus.outValid !== 1'b1 || bus.outPC4 !== 16'h0104 || bus.inReady !== 1'b1) begin n_fail++; $display("FAIL fill_out2: got v%b pc %h rdy %b want v1 0104 rdy1", bus.outValid, bus.outPC4, bus.inReady); end
        step();
        n_checks++; if (bus.outValid !== 1'b1 || bus.outPC4 !== 16'h0106 || bus.outInstruction !== 16'h3333) begin n_fail++; $display("FAIL fill_out3: got v%b pc %h ins %h want v1 0106 3333", bus.outValid, bus.outPC4, bus.outInstruction); end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL fill_drain: got %b want 0", bus.outValid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 16'h0202, 16'h4444, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0204, 16'h5555, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0BAD, 16'hBAD0, 1'b1, 1'b1); step();
        n_checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin n_fail++; $display("FAIL flush_state: got v%b rdy %b want v0 rdy1", bus.outValid, bus.inReady); end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); step();
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got v%b pc %h want v0", bus.outValid, bus.outPC4); end
        drive(1'b1, 16'h0300, 16'h6666, 1'b0, 1'b0); step();
        n_checks++; if (bus.outValid !== 1'b1 || bus.outPC4 !== 16'h0300) begin n_fail++; $display("FAIL flush_next: got v%b pc %h want v1 0300", bus.outValid, bus.outPC4); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 16'h0400, 16'h7777, 1'b0, 1'b0); step();
        drive(1'b1, 16'h0402, 16'h8888, 1'b0, 1'b0); step();
        n_checks++; if (bus.outValid !== 1'b1 || bus.outPC4 !== 16'h0402 || bus.inReady !== 1'b1) begin n_fail++; $display("FAIL pass_through: got v%b pc %h rdy %b want v1 0402 rdy1", bus.outValid, bus.outPC4, bus.inReady); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 16'h0500, 16'h9999, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0502, 16'hAAAA, 1'b1, 1'b0); step();
        drive(1'b1, 16'h0504, 16'hBBBB, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin n_fail++; $display("FAIL rst_stall_state: got v%b rdy %b want v0 rdy1", bus.outValid, bus.inReady); end
        n_checks++; if (bus.stallCount !== 16'h0000 || bus.outPC4 !== 16'h0000) begin n_fail++; $display("FAIL rst_stall_data: got cnt %h pc %h want 0000 0000", bus.stallCount, bus.outPC4); end
    endtask

    task automatic test_stall_count();
        do_reset();
        drive(1'b1, 16'h0600, 16'hCCCC, 1'b1, 1'b0); step();
        bus.inValid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (bus.stallCount !== 16'd5) begin n_fail++; $display("FAIL count_five: got %0d want 5", bus.stallCount); end
        bus.stall = 1'b0; step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (bus.stallCount !== 16'd5) begin n_fail++; $display("FAIL count_empty: got %0d want 5", bus.stallCount); end
        do_reset();
        drive(1'b1, 16'h0700, 16'hDDDD, 1'b1, 1'b0); step();
        bus.inValid = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            step();
            if (i == 65533) begin
                n_checks++; if (bus.stallCount !== 16'hFFFE) begin n_fail++; $display("FAIL count_fffe: got %h want FFFE", bus.stallCount); end
            end
        end
        n_checks++; if (bus.stallCount !== 16'hFFFF) begin n_fail++; $display("FAIL count_sat: got %h want FFFF", bus.stallCount); end
    endtask

    task automatic test_random();
        logic [15:0] e_ins;
        logic [15:0] e_imm;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
            reset = 1'($urandom_range(0, 499) == 0);
            step();
            reset = 1'b0;
            n_checks++; if (bus.outValid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", i, bus.outValid, mq.size() > 0); end
            n_checks++; if (bus.inReady !== m_ready) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", i, bus.inReady, m_ready); end
            n_checks++; if (bus.stallCount !== m_cnt) begin n_fail++; $display("FAIL rand_count@%0d: got %h want %h", i, bus.stallCount, m_cnt); end
            if (mq.size() > 0) begin
                e_ins = mq[0].ins;
                e_imm = (e_ins % 16 >= 8) ? (e_ins % 16) + 16'hFFF0 : e_ins % 16;
                n_checks++; if (bus.outPC4 !== mq[0].pc || bus.outInstruction !== e_ins) begin n_fail++; $display("FAIL rand_data@%0d: got %h/%h want %h/%h", i, bus.outPC4, bus.outInstruction, mq[0].pc, e_ins); end
                n_checks++; if (bus.outOpcode !== 4'(e_ins / 4096) || bus.outRs !== 4'((e_ins / 256) % 16) || bus.outRt !== 4'((e_ins / 16) % 16) || bus.outRd !== 4'(e_ins % 16)) begin n_fail++; $display("FAIL rand_fields@%0d: got %h%h%h%h want %h", i, bus.outOpcode, bus.outRs, bus.outRt, bus.outRd, e_ins); end
                n_checks++; if (bus.outImm !== e_imm) begin n_fail++; $display("FAIL rand_imm@%0d: got %h want %h", i, bus.outImm, e_imm); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ready  = 1'b1;
        m_cnt    = 16'h0000;
        reset    = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_stall_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
